// File: rtl/emergency_dispatch_console_if.sv
// rtl/emergency_dispatch_console_if.sv - switch, UART and status bundle of the dispatch console
interface emergency_dispatch_console_if;
    logic [3:0] SW;
    logic       UART_RXD;
    logic       UART_TXD;
    logic [7:0] status_code;
    logic [3:0] status_timer;
    logic       status_valid;
    logic       link_ok;
    logic       cmd_ack;

    modport master (
        input  SW, UART_RXD,
        output UART_TXD, status_code, status_timer, status_valid, link_ok, cmd_ack
    );

    modport slave (
        output SW, UART_RXD,
        input  UART_TXD, status_code, status_timer, status_valid, link_ok, cmd_ack
    );
endinterface

// File: rtl/emergency_dispatch_console.sv
// rtl/emergency_dispatch_console.sv - operator console: sends N/S/E/W/C commands, parses status pairs
module emergency_dispatch_console #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RESEND_CYCLES = 100_000_000,
    parameter int LINK_TIMEOUT  = 150_000_000
) (
    input  logic                         CLOCK_50,
    input  logic [0:0]                   KEY,
    emergency_dispatch_console_if.master bus
);
    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam int RES_W = $clog2(RESEND_CYCLES);
    localparam int WD_W  = $clog2(LINK_TIMEOUT);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESEND_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LINK_TIMEOUT - 1);

    localparam logic [7:0] CODE_N = 8'h4E;
    localparam logic [7:0] CODE_S = 8'h53;
    localparam logic [7:0] CODE_E = 8'h45;
    localparam logic [7:0] CODE_W = 8'h57;
    localparam logic [7:0] CODE_C = 8'h43;

    logic rst_n;
    assign rst_n = KEY[0];

    // Switch synchroniser and fixed-priority command selection
    logic [3:0] sw_meta, sw_sync;
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= bus.SW;
            sw_sync <= sw_meta;
        end
    end

    logic [7:0] sel_code;
    always_comb begin
        sel_code = CODE_C;
        if (sw_sync[3]) sel_code = CODE_W;
        if (sw_sync[2]) sel_code = CODE_E;
        if (sw_sync[1]) sel_code = CODE_S;
        if (sw_sync[0]) sel_code = CODE_N;
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t        tx_state;
    logic [BIT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [RES_W-1:0] resend_cnt;
    logic [7:0]       cur_code;
    logic             pending;
    logic             txd;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            resend_cnt <= '0;
            cur_code   <= CODE_C;
            pending    <= 1'b1;
            txd        <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pending) begin
                        pending    <= 1'b0;
                        tx_shift   <= cur_code;
                        resend_cnt <= '0;
                        tx_cnt     <= '0;
                        txd        <= 1'b0;
                        tx_state   <= TX_START;
                    end else if (resend_cnt == RES_LAST) begin
                        pending <= 1'b1;
                    end else begin
                        resend_cnt <= resend_cnt + 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            txd      <= tx_shift[1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            // A selection change outranks the load-clear so the newest code is never lost
            if (sel_code != cur_code) begin
                cur_code <= sel_code;
                pending  <= 1'b1;
            end
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t        rx_state;
    logic             rxd_meta, rxd_sync;
    logic [BIT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_done;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
        end else begin
            rxd_meta <= bus.UART_RXD;
            rxd_sync <= rxd_meta;
            rx_done  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rxd_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit to reject glitches
                    if (rx_cnt == BIT_HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_done  <= rxd_sync;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic rx_is_code, rx_is_digit;
    assign rx_is_code  = (rx_shift == CODE_C) || (rx_shift == CODE_N) || (rx_shift == CODE_S) ||
                         (rx_shift == CODE_E) || (rx_shift == CODE_W);
    assign rx_is_digit = (rx_shift >= 8'h30) && (rx_shift <= 8'h39);

    typedef enum logic {P_WAIT_CODE, P_WAIT_DIGIT} p_state_t;
    p_state_t        p_state;
    logic [7:0]      code_latch;
    logic [WD_W-1:0] wd_cnt;
    logic [7:0]      status_code;
    logic [3:0]      status_timer;
    logic            status_valid;
    logic            link_ok;
    logic            commit;

    assign commit = rx_done && (p_state == P_WAIT_DIGIT) && rx_is_digit;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            p_state      <= P_WAIT_CODE;
            code_latch   <= CODE_C;
            status_code  <= CODE_C;
            status_timer <= '0;
            status_valid <= 1'b0;
            link_ok      <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            status_valid <= 1'b0;
            if (rx_done) begin
                case (p_state)
                    P_WAIT_CODE: begin
                        if (rx_is_code) begin
                            code_latch <= rx_shift;
                            p_state    <= P_WAIT_DIGIT;
                        end
                    end
                    P_WAIT_DIGIT: begin
                        if (rx_is_digit) begin
                            status_code  <= code_latch;
                            status_timer <= rx_shift[3:0];
                            status_valid <= 1'b1;
                            p_state      <= P_WAIT_CODE;
                        end else if (rx_is_code) begin
                            code_latch <= rx_shift;
                        end else begin
                            p_state <= P_WAIT_CODE;
                        end
                    end
                    default: p_state <= P_WAIT_CODE;
                endcase
            end
            // A commit landing on the timeout cycle keeps the link up
            if (commit) begin
                wd_cnt  <= '0;
                link_ok <= 1'b1;
            end else if (wd_cnt == WD_LAST) begin
                link_ok <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bus.UART_TXD     = txd;
    assign bus.status_code  = status_code;
    assign bus.status_timer = status_timer;
    assign bus.status_valid = status_valid;
    assign bus.link_ok      = link_ok;
    assign bus.cmd_ack      = link_ok && (status_code == cur_code);
endmodule

// File: tb/tb_emergency_dispatch_console.sv
// tb/tb_emergency_dispatch_console.sv - directed and randomized bench for emergency_dispatch_console
module tb_emergency_dispatch_console;
    localparam int CPB     = 8;
    localparam int RESEND  = 2000;
    localparam int TIMEOUT = 3000;

    logic       CLOCK_50 = 1'b0;
    logic [0:0] KEY;
    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_count = 0;

    emergency_dispatch_console_if bus();

    emergency_dispatch_console #(
        .CLKS_PER_BIT (CPB),
        .RESEND_CYCLES(RESEND),
        .LINK_TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .bus     (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (bus.status_valid === 1'b1) valid_count++;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] prio(input logic [3:0] sw);
        logic [7:0] codes [4];
        codes = '{8'h4E, 8'h53, 8'h45, 8'h57};
        for (int i = 0; i < 4; i++) if (sw[i]) return codes[i];
        return 8'h43;
    endfunction

    function automatic bit is_code_b(input logic [7:0] b);
        return (b == 8'h43) || (b == 8'h4E) || (b == 8'h53) || (b == 8'h45) || (b == 8'h57);
    endfunction

    function automatic bit is_digit_b(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] codes [5];
        codes = '{8'h43, 8'h4E, 8'h53, 8'h45, 8'h57};
        return codes[$urandom_range(0, 4)];
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return rand_code();
            1:       return 8'(8'h30 + $urandom_range(0, 9));
            2:       return 8'(8'h3A + $urandom_range(0, 5));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Samples 80 half-cycle-offset points of one frame; ok only if every bit holds for exactly CPB cycles
    task automatic capture_frame(input int limit, output logic [7:0] b, output int waited, output bit ok);
        logic wave [80];
        logic e;
        waited = 0;
        ok = 1'b0;
        b = '0;
        @(negedge CLOCK_50);
        while (bus.UART_TXD !== 1'b0 && waited < limit) begin
            @(negedge CLOCK_50);
            waited++;
        end
        if (bus.UART_TXD !== 1'b0) return;
        for (int i = 0; i < 80; i++) begin
            wave[i] = bus.UART_TXD;
            if (i < 79) @(negedge CLOCK_50);
        end
        ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i < 8)        e = 1'b0;
            else if (i >= 72) e = 1'b1;
            else              e = wave[8 * (i / 8) + 4];
            if (wave[i] !== e) ok = 1'b0;
        end
        for (int k = 0; k < 8; k++) b[k] = wave[8 * (k + 1) + 4];
    endtask

    task automatic quiet_for(input int n, output bit quiet);
        quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            if (bus.UART_TXD !== 1'b1) quiet = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(posedge CLOCK_50);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.UART_RXD = f[i];
            repeat (CPB) @(posedge CLOCK_50);
            #1;
        end
        bus.UART_RXD = 1'b1;
        repeat (3) @(posedge CLOCK_50);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] model_cur;
        logic [7:0] exp_code;
        logic [3:0] exp_timer;
        logic [3:0] sw;
        logic [7:0] q [$];
        int         waited;
        int         base;
        int         exp_commits;
        bit         ok;
        bit         quiet;

        KEY = 1'b0;
        bus.SW = 4'b0000;
        bus.UART_RXD = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check("rst_txd", bus.UART_TXD, 1'b1);
        check("rst_status_code", bus.status_code, 8'h43);
        check("rst_status_timer", bus.status_timer, 4'd0);
        check("rst_status_valid", bus.status_valid, 1'b0);
        check("rst_link_ok", bus.link_ok, 1'b0);
        check("rst_cmd_ack", bus.cmd_ack, 1'b0);

        KEY = 1'b1;
        capture_frame(200, b, waited, ok);
        check("first_frame_shape", ok, 1'b1);
        check("first_frame_byte", b, 8'h43);
        check("first_link_ok", bus.link_ok, 1'b0);
        check("first_cmd_ack", bus.cmd_ack, 1'b0);
        model_cur = 8'h43;

        bus.SW = 4'b0001;
        capture_frame(200, b, waited, ok);
        check("n_frame_shape", ok, 1'b1);
        check("n_frame_byte", b, 8'h4E);
        bus.SW = 4'b0011;
        quiet_for(1500, quiet);
        check("n_keeps_priority_quiet", quiet, 1'b1);
        capture_frame(3000, b, waited, ok);
        check("resend_shape", ok, 1'b1);
        check("resend_byte", b, 8'h4E);
        check("resend_gap", (1500 + 1 + waited >= 1990) && (1500 + 1 + waited <= 2020), 1'b1);
        model_cur = 8'h4E;

        bus.SW = 4'b0000;
        fork
            capture_frame(200, b, waited, ok);
            begin
                repeat (10) @(negedge CLOCK_50); bus.SW = 4'b0001;
                repeat (15) @(negedge CLOCK_50); bus.SW = 4'b0010;
                repeat (15) @(negedge CLOCK_50); bus.SW = 4'b0100;
            end
        join
        check("inflight_c_byte", b, 8'h43);
        capture_frame(200, b, waited, ok);
        check("inflight_latest_shape", ok, 1'b1);
        check("inflight_latest_byte", b, prio(4'b0100));
        quiet_for(300, quiet);
        check("inflight_single_frame", quiet, 1'b1);
        model_cur = prio(4'b0100);

        for (int it = 0; it < 6; it++) begin
            do sw = 4'($urandom_range(0, 15)); while (prio(sw) == model_cur);
            bus.SW = sw;
            capture_frame(200, b, waited, ok);
            check("rand_tx_shape", ok, 1'b1);
            check("rand_tx_byte", b, prio(sw));
            model_cur = prio(sw);
        end

        bus.SW = 4'b0001;
        if (model_cur != 8'h4E) begin
            capture_frame(200, b, waited, ok);
            check("n_select_byte", b, 8'h4E);
        end
        model_cur = 8'h4E;

        base = valid_count;
        send_byte(8'h4E);
        send_byte(8'h37);
        check("pair_valid_pulses", valid_count - base, 1);
        check("pair_status_code", bus.status_code, 8'h4E);
        check("pair_status_timer", bus.status_timer, 4'd7);
        check("pair_link_ok", bus.link_ok, 1'b1);
        check("pair_cmd_ack", bus.cmd_ack, 1'b1);

        base = valid_count;
        send_byte(8'h4E);
        send_byte(8'h41);
        check("bad_digit_no_commit", valid_count - base, 0);
        send_byte(8'h43);
        send_byte(8'h35);
        check("c_pair_valid_pulses", valid_count - base, 1);
        check("c_pair_status_code", bus.status_code, 8'h43);
        check("c_pair_status_timer", bus.status_timer, 4'd5);
        check("c_pair_cmd_ack", bus.cmd_ack, 1'b0);

        // A commit happens exactly when a digit immediately follows a code byte
        for (int round = 0; round < 3; round++) begin
            q.delete();
            for (int i = 0; i < 10; i++) q.push_back(rand_byte());
            q.push_back(rand_code());
            q.push_back(8'(8'h30 + $urandom_range(0, 9)));
            exp_commits = 0;
            exp_code = 8'h00;
            exp_timer = 4'd0;
            for (int i = 1; i < q.size(); i++) begin
                if (is_digit_b(q[i]) && is_code_b(q[i-1])) begin
                    exp_commits++;
                    exp_code = q[i-1];
                    exp_timer = 4'(q[i] - 8'h30);
                end
            end
            base = valid_count;
            foreach (q[i]) send_byte(q[i]);
            check("rand_rx_commits", valid_count - base, exp_commits);
            check("rand_rx_code", bus.status_code, exp_code);
            check("rand_rx_timer", bus.status_timer, exp_timer);
            check("rand_rx_link_ok", bus.link_ok, 1'b1);
            check("rand_rx_cmd_ack", bus.cmd_ack, exp_code == model_cur);
        end

        repeat (2900) @(negedge CLOCK_50);
        check("link_before_timeout", bus.link_ok, 1'b1);
        repeat (200) @(negedge CLOCK_50);
        check("link_after_timeout", bus.link_ok, 1'b0);
        check("ack_after_timeout", bus.cmd_ack, 1'b0);

        bus.SW = 4'b0000;
        waited = 0;
        @(negedge CLOCK_50);
        while (bus.UART_TXD !== 1'b0 && waited < 3000) begin
            @(negedge CLOCK_50);
            waited++;
        end
        check("frame_before_reset", bus.UART_TXD, 1'b0);
        repeat (2) @(negedge CLOCK_50);
        KEY = 1'b0;
        #1;
        check("reset_mid_frame_txd", bus.UART_TXD, 1'b1);
        check("reset_mid_frame_code", bus.status_code, 8'h43);
        check("reset_mid_frame_link", bus.link_ok, 1'b0);
        repeat (3) @(negedge CLOCK_50);
        KEY = 1'b1;
        capture_frame(200, b, waited, ok);
        check("post_reset_shape", ok, 1'b1);
        check("post_reset_byte", b, 8'h43);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
